multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter: STATE_W, default 4, width of the state register and the State port.
REQ-002 SHALL have port: CLK  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port: Reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: Op  in  6  Instr[31:26]; Funct  in  6  Instr[5:0]; Zero  in  1  datapath ALU zero flag.
REQ-005 SHALL have port: MemReady  in  1  unified memory completes the current access this cycle.
REQ-006 SHALL have 1-bit outputs: IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, InstrDone, IllegalOp.
REQ-007 SHALL have outputs: ALUSrcB  out  2; PCSrc  out  2; ALUControl  out  3; State  out  STATE_W (debug).

Function
REQ-008 SHALL be a Moore FSM with encodings FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11; codes 12-15 go to FETCH on the next edge.
REQ-009 Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
REQ-010 Transitions: FETCH->DECODE when MemReady, else hold; DECODE->MEMADR (lw/sw), EXECUTE (R), BRANCH (beq), ADDIEXEC (addi), JUMP (j); any other Op -> FETCH.
REQ-011 Transitions: MEMADR->MEMREAD (lw) or MEMWRITE (sw); MEMREAD->MEMWB when MemReady, else hold; MEMWRITE->FETCH when MemReady, else hold; EXECUTE->ALUWB, or FETCH on illegal Funct; ADDIEXEC->ADDIWB; MEMWB, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
REQ-012 Outputs not listed for a state SHALL be 0.
REQ-013 FETCH: ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00; IRWrite=PCEn=MemReady.
REQ-014 DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010 (branch target precompute).
REQ-015 MEMADR and ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUControl=010.
REQ-016 MEMREAD: IorD=1. MEMWRITE: IorD=1, MemWrite=1 held until MemReady.
REQ-017 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. ALUWB: RegWrite=1, RegDst=1. ADDIWB: RegWrite=1, RegDst=0.
REQ-018 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl by Funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; other Funct -> 010.
REQ-019 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, PCEn=Zero (combinational). JUMP: PCSrc=10, PCEn=1.
REQ-020 InstrDone SHALL pulse 1 cycle in the final state of each legal instruction: MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, and MEMWRITE when MemReady.
REQ-021 IllegalOp SHALL pulse 1 cycle, registered, on DECODE with unknown Op or EXECUTE with unknown Funct; no RegWrite/MemWrite/PCEn results.
REQ-022 Latency when MemReady is 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles.
REQ-023 MemWrite SHALL never assert in FETCH or MEMREAD; IRWrite only in FETCH.

Reset
REQ-024 Reset=1 SHALL asynchronously force State=FETCH and IllegalOp=0; other outputs then follow FETCH decoding.
REQ-025 Reset mid-instruction SHALL abandon it; no further RegWrite/MemWrite from it after deassertion.

Structure
REQ-026 Opcode, Funct, ALUControl and state encodings SHALL live in shared package mips_ctrl_pkg.
REQ-027 The Funct-to-ALUControl decode SHALL be sub-module alu_decoder (combinational), also reusable by Control_unit.

Verification
REQ-028 lw (Op=100011), MemReady=1 -> states 0,1,2,3,4; RegWrite=1, MemtoReg=1 in cycle 5; InstrDone once.
REQ-029 sw, MemReady low 3 cycles in MEMWRITE -> MemWrite held 4 cycles, single InstrDone, then FETCH.
REQ-030 beq with Zero=1 then Zero=0 -> PCEn=1, PCSrc=01 in BRANCH, then PCEn=0 in BRANCH.
REQ-031 R-type Funct 101010 -> ALUControl=111 in EXECUTE; Funct 000111 -> IllegalOp pulse, no RegWrite, back to FETCH.
REQ-032 Op=111111 -> IllegalOp pulse after DECODE; Reset asserted in MEMREAD -> State=0 immediately, no MEMWB.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// Holds the opcode and funct field values, the 3-bit ALU operation codes,
// the ALU source-B / PC source select codes and the controller state encoding.
// Any block that decodes instructions or drives the datapath imports this
// package, so everyone agrees on the same numbers.
package mips_ctrl_pkg;

  // Instr[31:26] opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Instr[5:0] funct codes for R-type instructions
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU operation codes seen by the datapath ALU
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU source-B mux selects
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // PC source mux selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Controller states; codes 12-15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational R-type funct decoder.
// Maps an instruction funct field onto the 3-bit ALU operation and flags
// whether the funct is one the datapath supports. Unsupported functs still
// produce an ADD code so the ALU inputs are never undefined.
// Ports:
//   funct       in  6  Instr[5:0]
//   alu_control out 3  ALU operation for this funct
//   funct_legal out 1  funct is a supported R-type operation
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_legal
);

  // Table lookup with ADD / illegal as the fall-through
  always_comb begin
    alu_control = ALU_ADD;
    funct_legal = 1'b1;
    case (funct)
      FUNCT_ADD: alu_control = ALU_ADD;
      FUNCT_SUB: alu_control = ALU_SUB;
      FUNCT_AND: alu_control = ALU_AND;
      FUNCT_OR:  alu_control = ALU_OR;
      FUNCT_SLT: alu_control = ALU_SLT;
      default: begin
        alu_control = ALU_ADD;
        funct_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style controller for a multicycle MIPS datapath with a unified,
// variable-latency memory.
// Ports:
//   CLK, Reset              clock, asynchronous active-high reset
//   Op, Funct               Instr[31:26] and Instr[5:0]
//   Zero                    ALU zero flag (beq decision)
//   MemReady                memory finishes the current access this cycle
//   IorD .. IllegalOp       1-bit datapath enables / status
//   ALUSrcB, PCSrc          mux selects
//   ALUControl              ALU operation
//   State                   current state code for debug
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic               PCEn,
  output logic               InstrDone,
  output logic               IllegalOp,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [2:0]         ALUControl,
  output logic [STATE_W-1:0] State
);

  state_t     state_q;
  state_t     state_d;
  logic       illegal_q;
  logic       illegal_d;
  logic [2:0] funct_alu_control;
  logic       funct_legal;

  alu_decoder u_alu_decoder (
    .funct       (Funct),
    .alu_control (funct_alu_control),
    .funct_legal (funct_legal)
  );

  // State and the IllegalOp flag; reset abandons any instruction in flight
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state. An unknown opcode or funct is flagged for exactly one cycle
  // and the controller returns to FETCH without touching any architectural
  // state. Terminal states and unused codes all fall through to FETCH.
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTE: begin
        if (funct_legal) begin
          state_d = S_ALUWB;
        end else begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode from the current state. Memory handshakes (FETCH,
  // MEMWRITE) and the beq decision use the live MemReady / Zero inputs so
  // the enables line up with the cycle the memory or ALU result is valid.
  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    PCEn       = 1'b0;
    InstrDone  = 1'b0;
    ALUSrcB    = SRCB_REG;
    PCSrc      = PCSRC_ALU;
    ALUControl = ALU_AND;
    case (state_q)
      S_FETCH: begin
        ALUSrcB    = SRCB_FOUR;
        ALUControl = ALU_ADD;
        PCSrc      = PCSRC_ALU;
        IRWrite    = MemReady;
        PCEn       = MemReady;
      end
      S_DECODE: begin
        ALUSrcB    = SRCB_BRANCH;
        ALUControl = ALU_ADD;
      end
      S_MEMADR, S_ADDIEXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = ALU_ADD;
      end
      S_MEMREAD: begin
        IorD = 1'b1;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        InstrDone = 1'b1;
      end
      S_MEMWRITE: begin
        IorD      = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = MemReady;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_REG;
        ALUControl = funct_alu_control;
      end
      S_ALUWB: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        InstrDone = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_REG;
        ALUControl = ALU_SUB;
        PCSrc      = PCSRC_ALUOUT;
        PCEn       = Zero;
        InstrDone  = 1'b1;
      end
      S_ADDIWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_JUMP: begin
        PCSrc     = PCSRC_JUMP;
        PCEn      = 1'b1;
        InstrDone = 1'b1;
      end
      default: begin
        IorD = 1'b0;
      end
    endcase
  end

  assign IllegalOp = illegal_q;
  assign State     = STATE_W'(state_q);

endmodule
